// File: rtl/glitch_seq_if.sv
// rtl/glitch_seq_if.sv - Control, status and FIFO read-side signals of glitch_seq
// GLITCH_SEQ_TRIG_EN adds the asynchronous trig input.
interface glitch_seq_if;
   logic        en;
   logic        abort;
   logic [31:0] fifo_in;
   logic        fifo_empty;
   logic        fifo_re;
   logic        ready;
   logic        glitch_en;
   logic        delay_en;
   logic [7:0]  busy_cnt;
`ifdef GLITCH_SEQ_TRIG_EN
   logic        trig;

   modport slave (
      input  en, abort, fifo_in, fifo_empty, trig,
      output fifo_re, ready, glitch_en, delay_en, busy_cnt
   );

   modport master (
      output en, abort, fifo_in, fifo_empty, trig,
      input  fifo_re, ready, glitch_en, delay_en, busy_cnt
   );
`else
   modport slave (
      input  en, abort, fifo_in, fifo_empty,
      output fifo_re, ready, glitch_en, delay_en, busy_cnt
   );

   modport master (
      output en, abort, fifo_in, fifo_empty,
      input  fifo_re, ready, glitch_en, delay_en, busy_cnt
   );
`endif
endinterface

// File: rtl/glitch_seq.sv
// rtl/glitch_seq.sv - Glitch sequencer: FIFO descriptors to timed delay_en/glitch_en windows
// GLITCH_SEQ_TRIG_EN adds a trigger-armed ARM state between LOAD and the timed phases.
module glitch_seq #(
   parameter int DELAY_W = 24,
   parameter int WIDTH_W = 8
) (
   input  logic        clk_i,
   input  logic        rst_i,
   glitch_seq_if.slave seq_io
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_LOAD,
      S_DELAY,
      S_GLITCH,
      S_NEXT
`ifdef GLITCH_SEQ_TRIG_EN
      , S_ARM
`endif
   } state_t;

   localparam logic [DELAY_W-1:0] CNT_ONE = DELAY_W'(1);

   state_t             state_q;
   logic [DELAY_W-1:0] cnt_q;
   logic [WIDTH_W-1:0] wid_q;
   logic [7:0]         busy_cnt_q;
   logic               fifo_re_q;
   logic               ready_q;
   logic               glitch_en_q;
   logic               delay_en_q;

   logic [DELAY_W-1:0] dly_src;
   logic [WIDTH_W-1:0] wid_src;
   logic [DELAY_W-1:0] wid_q_ext;
   logic               dispatch;
   state_t             disp_state;
   logic [DELAY_W-1:0] disp_cnt;

   assign wid_q_ext = {{(DELAY_W-WIDTH_W){1'b0}}, wid_q};

`ifdef GLITCH_SEQ_TRIG_EN
   logic [DELAY_W-1:0] dly_q;
   logic               trig_meta_q;
   logic               trig_sync_q;
   logic               trig_prev_q;
   logic               trig_rise;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         trig_meta_q <= 1'b0;
         trig_sync_q <= 1'b0;
         trig_prev_q <= 1'b0;
      end else begin
         trig_meta_q <= seq_io.trig;
         trig_sync_q <= trig_meta_q;
         trig_prev_q <= trig_sync_q;
      end
   end

   assign trig_rise = trig_sync_q & ~trig_prev_q;
`endif

   // Phase selection is shared by LOAD (live FIFO word) and ARM (captured word).
   always_comb begin
      dly_src = seq_io.fifo_in[WIDTH_W +: DELAY_W];
      wid_src = seq_io.fifo_in[WIDTH_W-1:0];
`ifdef GLITCH_SEQ_TRIG_EN
      dispatch = 1'b0;
      if (state_q == S_ARM) begin
         dly_src  = dly_q;
         wid_src  = wid_q;
         dispatch = trig_rise;
      end
`else
      dispatch = (state_q == S_LOAD);
`endif
      if (dly_src != '0) begin
         disp_state = S_DELAY;
         disp_cnt   = dly_src;
      end else if (wid_src != '0) begin
         disp_state = S_GLITCH;
         disp_cnt   = {{(DELAY_W-WIDTH_W){1'b0}}, wid_src};
      end else begin
         disp_state = S_NEXT;
         disp_cnt   = '0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         wid_q       <= '0;
         busy_cnt_q  <= '0;
         fifo_re_q   <= 1'b0;
         ready_q     <= 1'b1;
         glitch_en_q <= 1'b0;
         delay_en_q  <= 1'b0;
`ifdef GLITCH_SEQ_TRIG_EN
         dly_q       <= '0;
`endif
      end else if (seq_io.abort) begin
         // busy_cnt survives an abort so software can see how far it got
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         fifo_re_q   <= 1'b0;
         ready_q     <= 1'b1;
         glitch_en_q <= 1'b0;
         delay_en_q  <= 1'b0;
      end else begin
         fifo_re_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (seq_io.en && !seq_io.fifo_empty) begin
                  state_q    <= S_FETCH;
                  fifo_re_q  <= 1'b1;
                  ready_q    <= 1'b0;
                  busy_cnt_q <= '0;
               end
            end
            S_FETCH: state_q <= S_LOAD;
            S_LOAD: begin
               wid_q      <= wid_src;
               busy_cnt_q <= busy_cnt_q + 8'd1;
`ifdef GLITCH_SEQ_TRIG_EN
               dly_q      <= dly_src;
               state_q    <= S_ARM;
`endif
            end
`ifdef GLITCH_SEQ_TRIG_EN
            S_ARM: ;
`endif
            S_DELAY: begin
               if (cnt_q == CNT_ONE) begin
                  delay_en_q <= 1'b0;
                  if (wid_q != '0) begin
                     state_q     <= S_GLITCH;
                     glitch_en_q <= 1'b1;
                     cnt_q       <= wid_q_ext;
                  end else begin
                     state_q <= S_NEXT;
                     cnt_q   <= '0;
                  end
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            S_GLITCH: begin
               if (cnt_q == CNT_ONE) begin
                  glitch_en_q <= 1'b0;
                  state_q     <= S_NEXT;
                  cnt_q       <= '0;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            S_NEXT: begin
               if (!seq_io.fifo_empty) begin
                  state_q   <= S_FETCH;
                  fifo_re_q <= 1'b1;
               end else begin
                  state_q <= S_IDLE;
                  ready_q <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
               ready_q <= 1'b1;
            end
         endcase

         if (dispatch) begin
            state_q     <= disp_state;
            cnt_q       <= disp_cnt;
            delay_en_q  <= (disp_state == S_DELAY);
            glitch_en_q <= (disp_state == S_GLITCH);
         end
      end
   end

   assign seq_io.fifo_re   = fifo_re_q;
   assign seq_io.ready     = ready_q;
   assign seq_io.glitch_en = glitch_en_q;
   assign seq_io.delay_en  = delay_en_q;
   assign seq_io.busy_cnt  = busy_cnt_q;

endmodule

// File: tb/tb_glitch_seq.sv
// tb/tb_glitch_seq.sv - Directed self-checking bench for glitch_seq
module tb_glitch_seq;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en_r = 1'b0;
   logic        abort_r = 1'b0;
   logic [31:0] fifo_word = '0;
   logic        fifo_emp = 1'b1;
   int          checks = 0;
   int          errors = 0;

   glitch_seq_if s();
   assign s.en         = en_r;
   assign s.abort      = abort_r;
   assign s.fifo_in    = fifo_word;
   assign s.fifo_empty = fifo_emp;
`ifdef GLITCH_SEQ_TRIG_EN
   logic trig_r = 1'b0;
   assign s.trig = trig_r;
`endif

   glitch_seq dut (.clk_i(clk), .rst_i(rst), .seq_io(s));

   always #5 clk = ~clk;

   // FIFO model: a strobed read delivers the head word before the LOAD edge
   logic [31:0] fifo_q[$];
   int          rd_cnt = 0;
   always @(negedge clk) begin
      if (s.fifo_re === 1'b1) begin
         rd_cnt++;
         if (fifo_q.size() > 0) fifo_word = fifo_q.pop_front();
      end
      fifo_emp = (fifo_q.size() == 0);
   end

   logic [63:0] d_vec, g_vec, r_vec, rdy_vec;
   int          overlap;

   // Pulses en, then records 64 cycles; index 0 is the cycle after en is sampled.
   task automatic run_seq(input int en2_at);
      d_vec = '0; g_vec = '0; r_vec = '0; rdy_vec = '0; overlap = 0;
      @(negedge clk); en_r = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(negedge clk);
         en_r = (i == en2_at);
         d_vec[i]   = s.delay_en;
         g_vec[i]   = s.glitch_en;
         r_vec[i]   = s.fifo_re;
         rdy_vec[i] = s.ready;
         if (s.delay_en && s.glitch_en) overlap++;
      end
      en_r = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (s.ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", s.ready); end
      checks++; if (s.fifo_re !== 1'b0) begin errors++; $display("FAIL reset_fifo_re got %b exp 0", s.fifo_re); end
      checks++; if (s.glitch_en !== 1'b0) begin errors++; $display("FAIL reset_glitch_en got %b exp 0", s.glitch_en); end
      checks++; if (s.delay_en !== 1'b0) begin errors++; $display("FAIL reset_delay_en got %b exp 0", s.delay_en); end
      checks++; if (s.busy_cnt !== 8'd0) begin errors++; $display("FAIL reset_busy_cnt got %0d exp 0", s.busy_cnt); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_single;
      int rd0 = rd_cnt;
      fifo_q.push_back(32'h0000_0A05);
      run_seq(-1);
      checks++; if (r_vec !== 64'h1) begin errors++; $display("FAIL single_fifo_re got %h exp %h", r_vec, 64'h1); end
      checks++; if (d_vec !== 64'h0FFC) begin errors++; $display("FAIL single_delay got %h exp %h", d_vec, 64'h0FFC); end
      checks++; if (g_vec !== 64'h1_F000) begin errors++; $display("FAIL single_glitch got %h exp %h", g_vec, 64'h1_F000); end
      checks++; if (rdy_vec !== 64'hFFFF_FFFF_FFFC_0000) begin errors++; $display("FAIL single_ready got %h exp %h", rdy_vec, 64'hFFFF_FFFF_FFFC_0000); end
      checks++; if (s.busy_cnt !== 8'd1) begin errors++; $display("FAIL single_busy got %0d exp 1", s.busy_cnt); end
      checks++; if (rd_cnt - rd0 !== 1) begin errors++; $display("FAIL single_reads got %0d exp 1", rd_cnt - rd0); end
      checks++; if (overlap !== 0) begin errors++; $display("FAIL single_overlap got %0d exp 0", overlap); end
   endtask

   task automatic test_three;
      int rd0 = rd_cnt;
      fifo_q.push_back(32'h0000_0301);
      fifo_q.push_back(32'h0000_0002);
      fifo_q.push_back(32'h0000_0000);
      run_seq(-1);
      checks++; if (r_vec !== 64'h1081) begin errors++; $display("FAIL three_fifo_re got %h exp %h", r_vec, 64'h1081); end
      checks++; if (d_vec !== 64'h1C) begin errors++; $display("FAIL three_delay got %h exp %h", d_vec, 64'h1C); end
      checks++; if (g_vec !== 64'h620) begin errors++; $display("FAIL three_glitch got %h exp %h", g_vec, 64'h620); end
      checks++; if (rdy_vec !== 64'hFFFF_FFFF_FFFF_8000) begin errors++; $display("FAIL three_ready got %h exp %h", rdy_vec, 64'hFFFF_FFFF_FFFF_8000); end
      checks++; if (s.busy_cnt !== 8'd3) begin errors++; $display("FAIL three_busy got %0d exp 3", s.busy_cnt); end
      checks++; if (rd_cnt - rd0 !== 3) begin errors++; $display("FAIL three_reads got %0d exp 3", rd_cnt - rd0); end
   endtask

   task automatic test_en_ignored;
      int rd0 = rd_cnt;
      int rdy_low = 0;
      @(negedge clk); en_r = 1'b1;
      @(negedge clk); en_r = 1'b0;
      repeat (6) begin
         if (s.ready !== 1'b1) rdy_low++;
         @(negedge clk);
      end
      checks++; if (rdy_low !== 0) begin errors++; $display("FAIL empty_ready got %0d low cycles exp 0", rdy_low); end
      checks++; if (rd_cnt - rd0 !== 0) begin errors++; $display("FAIL empty_reads got %0d exp 0", rd_cnt - rd0); end
      fifo_q.push_back(32'h0000_0403);
      run_seq(4);
      checks++; if (r_vec !== 64'h1) begin errors++; $display("FAIL busy_en_fifo_re got %h exp %h", r_vec, 64'h1); end
      checks++; if (d_vec !== 64'h3C) begin errors++; $display("FAIL busy_en_delay got %h exp %h", d_vec, 64'h3C); end
      checks++; if (g_vec !== 64'h1C0) begin errors++; $display("FAIL busy_en_glitch got %h exp %h", g_vec, 64'h1C0); end
      checks++; if (rdy_vec !== 64'hFFFF_FFFF_FFFF_FC00) begin errors++; $display("FAIL busy_en_ready got %h exp %h", rdy_vec, 64'hFFFF_FFFF_FFFF_FC00); end
      checks++; if (s.busy_cnt !== 8'd1) begin errors++; $display("FAIL busy_en_busy got %0d exp 1", s.busy_cnt); end
   endtask

   task automatic test_abort;
      int rd0 = rd_cnt;
      fifo_q.push_back(32'h0003_E801);
      fifo_q.push_back(32'h0000_0203);
      @(negedge clk); en_r = 1'b1;
      @(negedge clk); en_r = 1'b0;
      repeat (500) @(negedge clk);
      checks++; if (s.delay_en !== 1'b1) begin errors++; $display("FAIL abort_pre_delay got %b exp 1", s.delay_en); end
      abort_r = 1'b1;
      @(negedge clk);
      abort_r = 1'b0;
      checks++; if (s.delay_en !== 1'b0) begin errors++; $display("FAIL abort_delay got %b exp 0", s.delay_en); end
      checks++; if (s.ready !== 1'b1) begin errors++; $display("FAIL abort_ready got %b exp 1", s.ready); end
      checks++; if (s.busy_cnt !== 8'd1) begin errors++; $display("FAIL abort_busy got %0d exp 1", s.busy_cnt); end
      repeat (3) @(negedge clk);
      checks++; if (rd_cnt - rd0 !== 1 || fifo_q.size() !== 1) begin errors++; $display("FAIL abort_fifo got reads %0d left %0d exp 1 1", rd_cnt - rd0, fifo_q.size()); end
      checks++; if (s.delay_en !== 1'b0 || s.ready !== 1'b1) begin errors++; $display("FAIL abort_idle got delay %b ready %b exp 0 1", s.delay_en, s.ready); end
      run_seq(-1);
      checks++; if (d_vec !== 64'hC) begin errors++; $display("FAIL resume_delay got %h exp %h", d_vec, 64'hC); end
      checks++; if (g_vec !== 64'h70) begin errors++; $display("FAIL resume_glitch got %h exp %h", g_vec, 64'h70); end
      checks++; if (rdy_vec !== 64'hFFFF_FFFF_FFFF_FF00) begin errors++; $display("FAIL resume_ready got %h exp %h", rdy_vec, 64'hFFFF_FFFF_FFFF_FF00); end
   endtask

   task automatic test_long_fields;
      int nd = 0, ng = 0, ov = 0, cyc = 0;
      fifo_q.push_back(32'h0001_00FF);
      @(negedge clk); en_r = 1'b1;
      @(negedge clk); en_r = 1'b0;
      while (s.ready !== 1'b1 && cyc < 700) begin
         if (s.delay_en === 1'b1) nd++;
         if (s.glitch_en === 1'b1) ng++;
         if (s.delay_en === 1'b1 && s.glitch_en === 1'b1) ov++;
         cyc++;
         @(negedge clk);
      end
      checks++; if (cyc >= 700) begin errors++; $display("FAIL long_timeout got %0d cycles exp < 700", cyc); end
      checks++; if (nd !== 256) begin errors++; $display("FAIL long_delay got %0d exp 256", nd); end
      checks++; if (ng !== 255) begin errors++; $display("FAIL long_glitch got %0d exp 255", ng); end
      checks++; if (ov !== 0) begin errors++; $display("FAIL long_overlap got %0d exp 0", ov); end
   endtask

`ifdef GLITCH_SEQ_TRIG_EN
   task automatic test_trig;
      int early = 0;
      fifo_q.push_back(32'h0000_0203);
      @(negedge clk); en_r = 1'b1;
      @(negedge clk); en_r = 1'b0;
      repeat (10) begin
         if (s.delay_en !== 1'b0 || s.glitch_en !== 1'b0) early++;
         @(negedge clk);
      end
      checks++; if (early !== 0 || s.ready !== 1'b0) begin errors++; $display("FAIL trig_armed got early %0d ready %b exp 0 0", early, s.ready); end
      d_vec = '0; g_vec = '0;
      trig_r = 1'b1;
      for (int j = 1; j < 14; j++) begin
         @(negedge clk);
         d_vec[j] = s.delay_en;
         g_vec[j] = s.glitch_en;
      end
      trig_r = 1'b0;
      checks++; if (d_vec !== 64'h18) begin errors++; $display("FAIL trig_delay got %h exp %h", d_vec, 64'h18); end
      checks++; if (g_vec !== 64'hE0) begin errors++; $display("FAIL trig_glitch got %h exp %h", g_vec, 64'hE0); end
      checks++; if (s.ready !== 1'b1) begin errors++; $display("FAIL trig_ready got %b exp 1", s.ready); end
   endtask
`endif

   task automatic test_reset_mid_glitch;
      int rd0 = rd_cnt;
      fifo_q.push_back(32'h0000_0014);
      fifo_q.push_back(32'h0000_0A05);
      @(negedge clk); en_r = 1'b1;
      @(negedge clk); en_r = 1'b0;
      repeat (7) @(negedge clk);
      checks++; if (s.glitch_en !== 1'b1) begin errors++; $display("FAIL rstmid_pre_glitch got %b exp 1", s.glitch_en); end
      rst = 1'b1;
      @(negedge clk);
      checks++; if (s.glitch_en !== 1'b0) begin errors++; $display("FAIL rstmid_glitch got %b exp 0", s.glitch_en); end
      checks++; if (s.ready !== 1'b1) begin errors++; $display("FAIL rstmid_ready got %b exp 1", s.ready); end
      checks++; if (s.busy_cnt !== 8'd0) begin errors++; $display("FAIL rstmid_busy got %0d exp 0", s.busy_cnt); end
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (5) @(negedge clk);
      checks++; if (rd_cnt - rd0 !== 1 || fifo_q.size() !== 1) begin errors++; $display("FAIL rstmid_fifo got reads %0d left %0d exp 1 1", rd_cnt - rd0, fifo_q.size()); end
      checks++; if (s.glitch_en !== 1'b0 || s.delay_en !== 1'b0) begin errors++; $display("FAIL rstmid_idle got glitch %b delay %b exp 0 0", s.glitch_en, s.delay_en); end
      fifo_q.delete();
   endtask

   initial begin
      test_reset();
      test_single();
      test_three();
      test_en_ignored();
      test_abort();
      test_long_fields();
`ifdef GLITCH_SEQ_TRIG_EN
      test_trig();
`endif
      test_reset_mid_glitch();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/glitch_seq.md
Name: glitch_seq

Overview:
- Glitch sequencer. Consumes the 32-bit glitch descriptors queued by the Wishbone glitch register block through the glitch FIFO, and produces the timed glitch_en window for the glitch clock mux.
- One descriptor = one delay phase followed by one glitch phase. Descriptors execute back-to-back until the FIFO drains.
- Runs entirely in the target-clock domain, the FIFO read side. ready is reported back to the status register.

Parameters:
- DELAY_W, 24, delay field width; descriptor bits [31:8].
- WIDTH_W, 8, glitch-width field width; descriptor bits [7:0]. DELAY_W+WIDTH_W must equal 32.

Ports:
- clk_i  in  1  target clock (FIFO read clock)
- rst_i  in  1  synchronous active-high reset
- en  in  1  start pulse; sampled only in IDLE
- abort  in  1  abandon sequence; return to IDLE
- fifo_in  in  32  FIFO Q; valid the cycle after fifo_re
- fifo_empty  in  1  FIFO empty flag
- fifo_re  out  1  FIFO read strobe, one cycle per descriptor
- ready  out  1  high only in IDLE
- glitch_en  out  1  glitch window, registered
- delay_en  out  1  high during DELAY phase, registered
- busy_cnt  out  8  number of descriptors consumed since the last start; wraps at 255->0

Behaviour:
- Clock and reset: one clock, clk_i. Reset rst_i is synchronous and active-high.
- Reset values: state=IDLE, ready=1, fifo_re=0, glitch_en=0, delay_en=0, busy_cnt=0, internal counters=0.
- Reset or abort mid-operation:
  - Next edge returns to IDLE with all outputs at reset values, except that abort keeps busy_cnt.
  - Any in-flight fifo_re is not repeated.
  - If reset and abort are both high, reset wins.
- IDLE:
  - en=1 and fifo_empty=0 -> FETCH. busy_cnt clears to 0 on this transition.
  - en=1 and fifo_empty=1 -> stay in IDLE; ready stays 1; no fifo_re.
- FETCH: fifo_re=1 for exactly one cycle -> LOAD.
- LOAD:
  - Capture dly=fifo_in[31:8] and wid=fifo_in[7:0]; busy_cnt+=1.
  - dly!=0 -> DELAY. dly==0 and wid!=0 -> GLITCH. Both zero -> NEXT.
- DELAY:
  - delay_en=1 for exactly dly cycles.
  - Counter is loaded with dly, decrements, and exits when it reaches 1.
  - Then -> GLITCH if wid!=0, else NEXT.
- GLITCH:
  - glitch_en=1 for exactly wid cycles.
  - delay_en=0 during this phase.
  - Then -> NEXT.
- NEXT:
  - fifo_empty=0 -> FETCH. This gives a 3-cycle gap between descriptors: NEXT, FETCH, LOAD.
  - fifo_empty=1 -> IDLE.
- en while not IDLE: ignored.
- Max values: dly=2^24-1 and wid=255 run exactly; no counter overflow.
- glitch_en and delay_en are never both high. Both are 0 in every state except their own phase.
- Latency from the en pulse:
  - fifo_re asserts 1 cycle after en is sampled.
  - First delay_en or glitch_en asserts 3 cycles after en is sampled.

Optional Feature:
- Macro: GLITCH_SEQ_TRIG_EN.
- Defined:
  - Adds input port trig (1 bit, asynchronous target trigger), a 2-FF synchronizer, and a rising-edge detector.
  - LOAD goes to a new ARM state instead of going directly to DELAY, GLITCH or NEXT.
  - ARM holds all outputs low except ready=0. A synchronized rising edge then continues exactly as LOAD would have.
  - abort exits ARM.
  - Edges seen outside ARM are discarded.
- Undefined: no trig port, no ARM state; timing exactly as in Behaviour.

Test Plan:
- Reset: hold rst_i for 3 cycles mid-GLITCH (wid=20) -> next cycle glitch_en=0, ready=1, busy_cnt=0; FIFO not read again.
- Single descriptor 0x00000A05, en pulse -> fifo_re 1 cycle; delay_en high for exactly 10 cycles; then glitch_en high for exactly 5 cycles; ready=1 after NEXT; busy_cnt=1.
- Three descriptors (0x00000301, 0x00000002, 0x00000000) -> delay 3 then glitch 1; glitch 2 with no delay_en; third consumed with no pulses; 3-cycle gaps between descriptors; busy_cnt=3; fifo_re count=3.
- en with FIFO empty -> no fifo_re, ready stays 1. en pulse during DELAY -> no effect on timing.
- Abort in the middle of a 1000-cycle delay -> IDLE next cycle; delay_en=0; remaining FIFO words untouched; busy_cnt kept. A fresh en then resumes with the next word.
- GLITCH_SEQ_TRIG_EN defined, descriptor 0x00000203 -> no output before trig rises; first delay_en 3 cycles after the trig edge (2 synchronizer + 1 edge detect); 2-cycle delay then 3-cycle glitch.
